// File: rtl/alu_seq_core.sv
// rtl/alu_seq_core.sv - handshaked sequential ALU with multi-cycle multiply and divide
//
// Purpose: accepts one operation per valid/ready handshake, computes it (single
// cycle for logic/arith ops, WIDTH+1 cycle latency for shift-add multiply and
// restoring divide), then holds the result until the consumer takes it. A carry
// flag is kept across operations so ADDC/SUBB can chain multi-word arithmetic.
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   operand handshake; in_ready is high only when idle
//   A, B, Opcode          operands and 5-bit operation select
//   out_valid / out_ready result handshake; out_valid is high only when done
//   ALU_Out               2*WIDTH result
//   CarryOut              carry/borrow register
//   Zero                  ALU_Out == 0
//   DivZero               current result is a DIV/MOD with B == 0
//   Illegal               current result came from an unsupported opcode
//
// Configuration macro: ALU_DIV_EN builds the divider; without it DIV/MOD
// complete in one cycle with ALU_Out=0 and Illegal=1.

module alu_seq_core #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [4:0]         Opcode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] ALU_Out,
  output logic               CarryOut,
  output logic               Zero,
  output logic               DivZero,
  output logic               Illegal
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int HALF  = WIDTH / 2;

  localparam logic [4:0] OP_MUL = 5'h02;
  localparam logic [4:0] OP_DIV = 5'h03;
  localparam logic [4:0] OP_MOD = 5'h04;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [4:0]         r_op;
  logic [WIDTH-1:0]   r_b;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_out;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_carry;
  logic               r_divzero;
  logic               r_illegal;

  logic               w_accept;
  logic               w_multi;
  logic [WIDTH:0]     w_ext;
  logic               w_arith;
  logic [WIDTH-1:0]   w_res;
  logic [WIDTH-1:0]   w_hi;
  logic               w_cout;
  logic               w_cupd;
  logic               w_dz;
  logic               w_ill;
  logic [WIDTH:0]     w_madd;
  logic [2*WIDTH-1:0] w_step;
  logic [2*WIDTH-1:0] w_fin;
`ifdef ALU_DIV_EN
  logic [WIDTH:0]     w_trial;
`endif

  assign w_accept = in_valid && (r_state == S_IDLE);

  // Divide by zero never iterates: its fixed result is produced in one cycle.
`ifdef ALU_DIV_EN
  assign w_multi = (Opcode == OP_MUL) ||
                   (((Opcode == OP_DIV) || (Opcode == OP_MOD)) && (B != '0));
`else
  assign w_multi = (Opcode == OP_MUL);
`endif

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (w_accept) w_next = w_multi ? S_BUSY : S_DONE;
      end
      S_BUSY: begin
        if (r_cnt == CNT_W'(WIDTH - 1)) w_next = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Single-cycle datapath, evaluated on the raw inputs so the result can be
  // registered on the accept edge itself.
  always_comb begin
    w_ext   = '0;
    w_arith = 1'b0;
    w_res   = '0;
    w_hi    = '0;
    w_cout  = r_carry;
    w_cupd  = 1'b0;
    w_dz    = 1'b0;
    w_ill   = 1'b0;
    case (Opcode)
      5'h00: begin w_ext = {1'b0, A} + {1'b0, B};                        w_arith = 1'b1; end
      5'h01: begin w_ext = {1'b0, A} - {1'b0, B};                        w_arith = 1'b1; end
`ifdef ALU_DIV_EN
      OP_DIV: begin w_dz = (B == '0); w_res = '1; w_hi = A; end
      OP_MOD: begin w_dz = (B == '0); w_res = A; end
`else
      OP_DIV, OP_MOD: w_ill = 1'b1;
`endif
      5'h05: begin w_res = {A[WIDTH-2:0], 1'b0}; w_cout = A[WIDTH-1]; w_cupd = 1'b1; end
      5'h06: begin w_res = {1'b0, A[WIDTH-1:1]}; w_cout = A[0];       w_cupd = 1'b1; end
      5'h07: w_res = {A[WIDTH-2:0], A[WIDTH-1]};
      5'h08: w_res = {A[0], A[WIDTH-1:1]};
      5'h09: w_res = A & B;
      5'h0A: w_res = A | B;
      5'h0B: w_res = A ^ B;
      5'h0C: w_res = ~(A | B);
      5'h0D: w_res = ~(A & B);
      5'h0E: w_res = ~(A ^ B);
      5'h0F: w_res = {{(WIDTH-1){1'b0}}, (A > B)};
      5'h10: w_res = {{(WIDTH-1){1'b0}}, (A == B)};
      5'h1A: w_res = {{(WIDTH-1){1'b0}}, (A < B)};
      5'h11: begin w_ext = {1'b0, A} + (WIDTH+1)'(1);                    w_arith = 1'b1; end
      5'h12: begin w_ext = {1'b0, A} - (WIDTH+1)'(1);                    w_arith = 1'b1; end
      5'h13: w_res = ~A;
      5'h14: begin w_ext = (WIDTH+1)'(0) - {1'b0, A};                    w_arith = 1'b1; end
      5'h15: w_res = {A[WIDTH-1], A[WIDTH-1:1]};
      5'h16: begin w_ext = {1'b0, A} + {1'b0, B} + (WIDTH+1)'(r_carry);  w_arith = 1'b1; end
      5'h17: begin w_ext = {1'b0, A} - {1'b0, B} - (WIDTH+1)'(r_carry);  w_arith = 1'b1; end
      5'h18: w_res = (A < B) ? A : B;
      5'h19: w_res = (A > B) ? A : B;
      5'h1B: w_res = A;
      5'h1C: w_res = B;
      5'h1D: w_res = (A > B) ? (A - B) : (B - A);
      5'h1E: w_res = {A[HALF-1:0], A[WIDTH-1:HALF]};
      5'h1F: w_ill = 1'b1;
      default: ;
    endcase
    // Top bit of the WIDTH+1 result is the carry, or the borrow for subtracts.
    if (w_arith) begin
      w_res  = w_ext[WIDTH-1:0];
      w_cout = w_ext[WIDTH];
      w_cupd = 1'b1;
    end
  end

  // Iterative datapath. r_acc is {high, low}: for MUL the product grows into
  // the high half while the multiplier shifts out of the low half; for DIV the
  // high half is the partial remainder and the low half turns from dividend
  // into quotient one bit per cycle.
  always_comb begin
    w_madd = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
    w_step = {w_madd, r_acc[WIDTH-1:1]};
`ifdef ALU_DIV_EN
    w_trial = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]} - {1'b0, r_b};
    if (r_op != OP_MUL) begin
      if (!w_trial[WIDTH]) w_step = {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
      else                 w_step = {r_acc[2*WIDTH-2:0], 1'b0};
    end
`endif
    w_fin = w_step;
    if (r_op == OP_MOD) w_fin = {{WIDTH{1'b0}}, w_step[2*WIDTH-1:WIDTH]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_op      <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_out     <= '0;
      r_cnt     <= '0;
      r_carry   <= 1'b0;
      r_divzero <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op      <= Opcode;
            r_b       <= B;
            r_acc     <= {{WIDTH{1'b0}}, A};
            r_cnt     <= '0;
            r_divzero <= w_dz;
            r_illegal <= w_ill;
            if (w_cupd) r_carry <= w_cout;
            if (!w_multi) r_out <= {w_hi, w_res};
          end
        end
        S_BUSY: begin
          r_acc <= w_step;
          r_cnt <= r_cnt + CNT_W'(1);
          // The last iteration writes its result directly so out_valid rises
          // on the same edge the counter completes.
          if (r_cnt == CNT_W'(WIDTH - 1)) r_out <= w_fin;
        end
        default: ;
      endcase
    end
  end

  assign ALU_Out  = r_out;
  assign CarryOut = r_carry;
  assign Zero     = (r_out == '0);
  assign DivZero  = r_divzero;
  assign Illegal  = r_illegal;

endmodule

// File: tb/tb_alu_seq_core.sv
// tb/tb_alu_seq_core.sv - directed self-checking bench for alu_seq_core

module tb_alu_seq_core;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   A;
  logic [W-1:0]   B;
  logic [4:0]     Opcode;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] ALU_Out;
  logic           CarryOut;
  logic           Zero;
  logic           DivZero;
  logic           Illegal;

  always #5 clk = ~clk;

  alu_seq_core #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Opcode(Opcode),
    .out_valid(out_valid), .out_ready(out_ready),
    .ALU_Out(ALU_Out), .CarryOut(CarryOut), .Zero(Zero),
    .DivZero(DivZero), .Illegal(Illegal)
  );

  typedef struct {
    logic [4:0] op;
    logic [7:0] a;
    logic [7:0] b;
    int         hold;
    bit         lit;
    logic [15:0] lo;
    int         lc;
    int         ll;
  } vec_t;

  vec_t vq[$];

  int n_vec = 0;
  int n_miss = 0;
  int cur_idx = -1;
  bit chk_en = 1'b0;
  logic [15:0] exp_out;
  logic exp_c, exp_dz, exp_il;
  logic model_carry;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s (vec %0d): got %h want %h", name, cur_idx, got, want);
    end
  endtask

  // Reference rules written as plain integer arithmetic.
  task automatic model(input logic [4:0] op, input int unsigned a, input int unsigned b,
                       input logic cin, output logic [15:0] o, output logic c,
                       output logic dz, output logic il, output int lat);
    int unsigned m, r, s, cu;
    m = (1 << W) - 1; r = 0; cu = int'(cin);
    c = cin; dz = 1'b0; il = 1'b0; lat = 1;
    case (op)
      5'h00: begin s = a + b; r = s & m; c = (s > m); end
      5'h01: begin r = (a - b) & m; c = (a < b); end
      5'h02: begin r = a * b; lat = W + 1; end
`ifdef ALU_DIV_EN
      5'h03: begin
        if (b == 0) begin r = (a << W) | m; dz = 1'b1; end
        else begin r = ((a % b) << W) | (a / b); lat = W + 1; end
      end
      5'h04: begin
        if (b == 0) begin r = a; dz = 1'b1; end
        else begin r = a % b; lat = W + 1; end
      end
`else
      5'h03, 5'h04: il = 1'b1;
`endif
      5'h05: begin r = (a << 1) & m; c = ((a >> (W - 1)) & 1) != 0; end
      5'h06: begin r = a >> 1; c = (a & 1) != 0; end
      5'h07: r = ((a << 1) | (a >> (W - 1))) & m;
      5'h08: r = (a >> 1) | ((a & 1) << (W - 1));
      5'h09: r = a & b;
      5'h0A: r = a | b;
      5'h0B: r = a ^ b;
      5'h0C: r = ~(a | b) & m;
      5'h0D: r = ~(a & b) & m;
      5'h0E: r = ~(a ^ b) & m;
      5'h0F: r = (a > b) ? 1 : 0;
      5'h10: r = (a == b) ? 1 : 0;
      5'h1A: r = (a < b) ? 1 : 0;
      5'h11: begin s = a + 1; r = s & m; c = (s > m); end
      5'h12: begin r = (a - 1) & m; c = (a == 0); end
      5'h13: r = ~a & m;
      5'h14: begin r = (0 - a) & m; c = (a != 0); end
      5'h15: r = (a >> 1) | (a & (1 << (W - 1)));
      5'h16: begin s = a + b + cu; r = s & m; c = (s > m); end
      5'h17: begin r = (a - b - cu) & m; c = (a < b + cu); end
      5'h18: r = (a < b) ? a : b;
      5'h19: r = (a > b) ? a : b;
      5'h1B: r = a;
      5'h1C: r = b;
      5'h1D: r = (a > b) ? a - b : b - a;
      5'h1E: r = ((a & ((1 << (W / 2)) - 1)) << (W - W / 2)) | (a >> (W / 2));
      default: il = 1'b1;
    endcase
    o = r[15:0];
  endtask

  function automatic void add(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                              input int hold, input bit lit, input logic [15:0] lo,
                              input int lc, input int ll);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.hold = hold;
    v.lit = lit; v.lo = lo; v.lc = lc; v.ll = ll;
    vq.push_back(v);
  endfunction

  // Result checker: every cycle a result is presented it must match the model.
  always @(negedge clk) begin
    if (chk_en && !rst && out_valid) begin
      check("alu_out", 32'(ALU_Out), 32'(exp_out));
      check("carry",   32'(CarryOut), 32'(exp_c));
      check("zero",    32'(Zero), 32'(exp_out == 16'h0));
      check("divzero", 32'(DivZero), 32'(exp_dz));
      check("illegal", 32'(Illegal), 32'(exp_il));
      check("in_ready_in_done", 32'(in_ready), 32'(0));
    end
  end

  task automatic run(input vec_t v);
    logic [15:0] o;
    logic c, dz, il;
    int lat, got_lat;
    model(v.op, int'(v.a), int'(v.b), model_carry, o, c, dz, il, lat);
    @(negedge clk);
    check("in_ready_idle", 32'(in_ready), 32'(1));
    exp_out = o; exp_c = c; exp_dz = dz; exp_il = il; model_carry = c;
    A = v.a; B = v.b; Opcode = v.op; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; A = 8'($urandom); B = 8'($urandom); Opcode = 5'($urandom);
    got_lat = 0;
    while (1) begin
      @(negedge clk);
      got_lat++;
      if (out_valid) break;
      check("in_ready_busy", 32'(in_ready), 32'(0));
      if (got_lat > 4 * W) begin
        check("timeout_out_valid", 32'(out_valid), 32'(1));
        break;
      end
    end
    check("latency", 32'(got_lat), 32'(lat));
    if (v.lit) begin
      check("lit_out", 32'(ALU_Out), 32'(v.lo));
      check("lit_latency", 32'(got_lat), 32'(v.ll));
      if (v.lc >= 0) check("lit_carry", 32'(CarryOut), 32'(v.lc));
    end
    repeat (v.hold) begin
      @(negedge clk);
      check("in_ready_held", 32'(in_ready), 32'(0));
      check("out_valid_held", 32'(out_valid), 32'(1));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("out_valid_drop", 32'(out_valid), 32'(0));
    check("in_ready_back", 32'(in_ready), 32'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; Opcode = '0; model_carry = 1'b0;
    exp_out = '0; exp_c = 1'b0; exp_dz = 1'b0; exp_il = 1'b0;

    add(5'h00, 8'h67, 8'h98, 0, 1, 16'h00FF, 0, 1);
    add(5'h00, 8'hFF, 8'h01, 0, 1, 16'h0000, 1, 1);
    add(5'h16, 8'h00, 8'h00, 0, 1, 16'h0001, 0, 1);
    add(5'h02, 8'h67, 8'h98, 0, 1, 16'h3D28, 0, 9);
`ifdef ALU_DIV_EN
    add(5'h03, 8'h98, 8'h67, 0, 1, 16'h3101, 0, 9);
    add(5'h03, 8'h67, 8'h00, 0, 1, 16'h67FF, 0, 1);
    add(5'h04, 8'h64, 8'h07, 0, 1, 16'h0002, 0, 9);
    add(5'h04, 8'h05, 8'h00, 0, 1, 16'h0005, 0, 1);
    add(5'h03, 8'hFF, 8'h01, 0, 1, 16'h00FF, 0, 9);
`else
    add(5'h03, 8'h98, 8'h67, 0, 1, 16'h0000, 0, 1);
    add(5'h04, 8'h64, 8'h07, 0, 1, 16'h0000, 0, 1);
`endif
    add(5'h01, 8'h10, 8'h20, 5, 1, 16'h00F0, 1, 1);
    add(5'h17, 8'h30, 8'h10, 0, 1, 16'h001F, 0, 1);
    add(5'h05, 8'h81, 8'h00, 0, 1, 16'h0002, 1, 1);
    add(5'h06, 8'h02, 8'h00, 0, 1, 16'h0001, 0, 1);
    add(5'h07, 8'h81, 8'h00, 0, 1, 16'h0003, 0, 1);
    add(5'h08, 8'h01, 8'h00, 0, 1, 16'h0080, 0, 1);
    add(5'h09, 8'hA5, 8'h3C, 0, 1, 16'h0024, -1, 1);
    add(5'h0A, 8'hA5, 8'h3C, 0, 1, 16'h00BD, -1, 1);
    add(5'h0B, 8'hA5, 8'h3C, 0, 1, 16'h0099, -1, 1);
    add(5'h0C, 8'hA5, 8'h3C, 0, 1, 16'h0042, -1, 1);
    add(5'h0D, 8'hA5, 8'h3C, 1, 1, 16'h00DB, -1, 1);
    add(5'h0E, 8'hA5, 8'h3C, 0, 1, 16'h0066, -1, 1);
    add(5'h0F, 8'h05, 8'h03, 0, 1, 16'h0001, -1, 1);
    add(5'h10, 8'h07, 8'h07, 0, 1, 16'h0001, -1, 1);
    add(5'h1A, 8'h05, 8'h03, 0, 1, 16'h0000, -1, 1);
    add(5'h11, 8'hFF, 8'h00, 0, 1, 16'h0000, 1, 1);
    add(5'h12, 8'h00, 8'h00, 0, 1, 16'h00FF, 1, 1);
    add(5'h13, 8'h0F, 8'h00, 0, 1, 16'h00F0, 1, 1);
    add(5'h14, 8'h00, 8'h00, 0, 1, 16'h0000, 0, 1);
    add(5'h14, 8'h01, 8'h00, 0, 1, 16'h00FF, 1, 1);
    add(5'h15, 8'h80, 8'h00, 0, 1, 16'h00C0, 1, 1);
    add(5'h16, 8'h01, 8'h01, 0, 1, 16'h0003, 0, 1);
    add(5'h18, 8'h30, 8'h40, 0, 1, 16'h0030, -1, 1);
    add(5'h19, 8'h30, 8'h40, 0, 1, 16'h0040, -1, 1);
    add(5'h1B, 8'h5A, 8'h3C, 0, 1, 16'h005A, -1, 1);
    add(5'h1C, 8'h5A, 8'h3C, 0, 1, 16'h003C, -1, 1);
    add(5'h1D, 8'h10, 8'h30, 0, 1, 16'h0020, -1, 1);
    add(5'h1E, 8'hA5, 8'h00, 0, 1, 16'h005A, -1, 1);
    add(5'h1F, 8'h12, 8'h34, 0, 1, 16'h0000, 0, 1);
    add(5'h02, 8'hFF, 8'hFF, 2, 1, 16'hFE01, 0, 9);
    add(5'h02, 8'h00, 8'h37, 0, 1, 16'h0000, 0, 9);
    add(5'h00, 8'hFF, 8'h01, 0, 1, 16'h0000, 1, 1);
    add(5'h1B, 8'h5A, 8'h00, 0, 1, 16'h005A, 1, 1);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready",  32'(in_ready), 32'(1));
    check("reset_out_valid", 32'(out_valid), 32'(0));
    check("reset_alu_out",   32'(ALU_Out), 32'(0));
    check("reset_carry",     32'(CarryOut), 32'(0));
    check("reset_divzero",   32'(DivZero), 32'(0));
    check("reset_illegal",   32'(Illegal), 32'(0));
    chk_en = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      cur_idx = i;
      run(vq[i]);
    end

    // Abort a multiply three cycles in; carry and result must clear.
    cur_idx = 1000;
    @(negedge clk);
    A = 8'h67; B = 8'h98; Opcode = 5'h02; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_busy_in_ready", 32'(in_ready), 32'(0));
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    model_carry = 1'b0;
    @(negedge clk);
    check("abort_out_valid", 32'(out_valid), 32'(0));
    check("abort_in_ready",  32'(in_ready), 32'(1));
    check("abort_alu_out",   32'(ALU_Out), 32'(0));
    check("abort_carry",     32'(CarryOut), 32'(0));

    cur_idx = 1001;
    begin
      vec_t v;
      v.op = 5'h16; v.a = 8'h00; v.b = 8'h00; v.hold = 0;
      v.lit = 1; v.lo = 16'h0000; v.lc = 0; v.ll = 1;
      run(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
